// File: rtl/pb_pkg.sv
// Shared constants for the push-button conditioner: FSM state encoding,
// default timing for a 50 MHz clock and a helper for the counter-range check.
package pb_pkg;

  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] PRESS_WAIT   = 2'd1;
  localparam logic [1:0] PRESSED      = 2'd2;
  localparam logic [1:0] RELEASE_WAIT = 2'd3;

  localparam int DEF_CNT_WIDTH       = 26;
  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_REPEAT_DELAY    = 25000000;
  localparam int DEF_REPEAT_PERIOD   = 5000000;

  // Widest counter the range check below can evaluate without overflow.
  localparam int MAX_CNT_WIDTH = 62;

  function automatic bit cyclesFit(input int cntWidth, input longint cycles);
    return (cntWidth >= 1) && (cntWidth <= MAX_CNT_WIDTH) &&
           (cycles >= 1) && (cycles < (longint'(1) << cntWidth));
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous level; synchronous active-low
// reset clears both stages to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/pb_debounce_pulse.sv
// Push-button conditioner: synchronise, debounce, emit press/release strobes.
// Optional auto-repeat while held is enabled by defining PB_AUTOREPEAT_EN.
module pb_debounce_pulse
  import pb_pkg::*;
#(
  parameter int CNT_WIDTH       = DEF_CNT_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic BTN,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse
);

  generate
    if (!(cyclesFit(CNT_WIDTH, longint'(DEBOUNCE_CYCLES)) &&
          cyclesFit(CNT_WIDTH, longint'(REPEAT_DELAY)) &&
          cyclesFit(CNT_WIDTH, longint'(REPEAT_PERIOD)))) begin : gCfgErr
      $error("pb_debounce_pulse: cycle-count parameter out of range for CNT_WIDTH");
    end
  endgenerate

  localparam logic [CNT_WIDTH-1:0] DEB_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                 btnSync;
  logic [1:0]           state;
  logic [CNT_WIDTH-1:0] cnt;

  sync_2ff uSync (
    .clk (clk),
    .rst (rst),
    .d   (BTN),
    .q   (btnSync)
  );

`ifdef PB_AUTOREPEAT_EN
  localparam logic [CNT_WIDTH-1:0] DELAY_LAST  = CNT_WIDTH'(REPEAT_DELAY - 1);
  localparam logic [CNT_WIDTH-1:0] PERIOD_LAST = CNT_WIDTH'(REPEAT_PERIOD - 1);

  // Set once the first (long) repeat interval has elapsed; later repeats use
  // the shorter period.
  logic repArmed;
`endif

  // cnt is shared: debounce timer in the *_WAIT states, repeat timer in PRESSED.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
`ifdef PB_AUTOREPEAT_EN
      repArmed      <= 1'b0;
`endif
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (btnSync) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
`ifdef PB_AUTOREPEAT_EN
            repArmed <= 1'b0;
`endif
          end
        end
        PRESS_WAIT: begin
          if (!btnSync) begin
            state <= IDLE;
          end else if (cnt == DEB_LAST) begin
            state       <= PRESSED;
            cnt         <= '0;
            btn_level   <= 1'b1;
            press_pulse <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (!btnSync) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
`ifdef PB_AUTOREPEAT_EN
            repArmed <= 1'b0;
          end else if (cnt == (repArmed ? PERIOD_LAST : DELAY_LAST)) begin
            press_pulse <= 1'b1;
            cnt         <= '0;
            repArmed    <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
`endif
          end
        end
        RELEASE_WAIT: begin
          if (btnSync) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            state         <= IDLE;
            btn_level     <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pb_debounce_pulse.sv
// Directed bench for pb_debounce_pulse with DEBOUNCE_CYCLES=4 (plus a
// DEBOUNCE_CYCLES=1 instance); expectations follow PB_AUTOREPEAT_EN.
module tb_pb_debounce_pulse;

`ifdef PB_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic BTN;
  logic BTN1;
  logic btn_level, press_pulse, release_pulse;
  logic lvl1, press1, rel1;

  int nTests = 0;
  int nFail  = 0;

  always #5 clk = ~clk;

  pb_debounce_pulse #(
    .CNT_WIDTH(8), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
  ) dut (
    .clk(clk), .rst(rst), .BTN(BTN),
    .btn_level(btn_level), .press_pulse(press_pulse), .release_pulse(release_pulse)
  );

  pb_debounce_pulse #(
    .CNT_WIDTH(8), .DEBOUNCE_CYCLES(1), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
  ) dut1 (
    .clk(clk), .rst(rst), .BTN(BTN1),
    .btn_level(lvl1), .press_pulse(press1), .release_pulse(rel1)
  );

  // Outputs are sampled 1 time unit after each rising edge; inputs change there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    BTN = 1'b0;
    BTN1 = 1'b0;
    repeat (3) step();
    nTests++;
    if (btn_level !== 1'b0) begin
      nFail++; $display("FAIL reset_level: got %b expected 0", btn_level);
    end
    nTests++;
    if (press_pulse !== 1'b0) begin
      nFail++; $display("FAIL reset_press: got %b expected 0", press_pulse);
    end
    nTests++;
    if (release_pulse !== 1'b0) begin
      nFail++; $display("FAIL reset_release: got %b expected 0", release_pulse);
    end
    rst = 1'b1;
    repeat (10) step();
  endtask

  // BTN high for holdCycles samples, then low; step index i counts edges from the rise.
  task automatic hold_and_release(input string name, input int holdCycles);
    logic [2:0] got, exp;
    logic expPress;
    BTN = 1'b1;
    for (int i = 1; i <= holdCycles + 12; i++) begin
      step();
      expPress = (i == 7) ||
                 (AR && i >= 17 && i <= holdCycles + 2 && ((i - 17) % 3) == 0);
      exp = {(i >= 7 && i < holdCycles + 7), expPress, (i == holdCycles + 7)};
      got = {btn_level, press_pulse, release_pulse};
      nTests++;
      if (got !== exp) begin
        nFail++;
        $display("FAIL %s step %0d: {level,press,release}=%b expected %b", name, i, got, exp);
      end
      if (i == holdCycles) BTN = 1'b0;
    end
    repeat (4) step();
  endtask

  task automatic test_press();
    hold_and_release("press", 20);
  endtask

  task automatic test_autorepeat();
    hold_and_release("autorepeat", 30);
  endtask

  task automatic test_glitch();
    logic [2:0] got;
    BTN = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      step();
      got = {btn_level, press_pulse, release_pulse};
      nTests++;
      if (got !== 3'b000) begin
        nFail++;
        $display("FAIL glitch step %0d: {level,press,release}=%b expected 000", i, got);
      end
      if (i == 3) BTN = 1'b0;
    end
  endtask

  task automatic test_bounce();
    logic [2:0] got, exp;
    BTN = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      step();
      exp = {(i >= 7 && i < 29), (i == 7), (i == 29)};
      got = {btn_level, press_pulse, release_pulse};
      nTests++;
      if (got !== exp) begin
        nFail++;
        $display("FAIL bounce step %0d: {level,press,release}=%b expected %b", i, got, exp);
      end
      if (i == 10) BTN = 1'b0;
      if (i == 12) BTN = 1'b1;
      if (i == 22) BTN = 1'b0;
    end
    repeat (4) step();
  endtask

  task automatic test_reset_mid();
    logic [2:0] got, exp;
    BTN = 1'b1;
    repeat (5) step();
    rst = 1'b0;
    step();
    got = {btn_level, press_pulse, release_pulse};
    nTests++;
    if (got !== 3'b000) begin
      nFail++;
      $display("FAIL reset_mid: {level,press,release}=%b expected 000", got);
    end
    rst = 1'b1;
    for (int i = 7; i <= 16; i++) begin
      step();
      exp = {(i >= 13), (i == 13), 1'b0};
      got = {btn_level, press_pulse, release_pulse};
      nTests++;
      if (got !== exp) begin
        nFail++;
        $display("FAIL reset_repress step %0d: {level,press,release}=%b expected %b", i, got, exp);
      end
    end
    BTN = 1'b0;
    repeat (14) step();
  endtask

  task automatic test_min_debounce();
    logic [2:0] got, exp;
    BTN1 = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      exp = {(i >= 4 && i < 10), (i == 4), (i == 10)};
      got = {lvl1, press1, rel1};
      nTests++;
      if (got !== exp) begin
        nFail++;
        $display("FAIL min_debounce step %0d: {level,press,release}=%b expected %b", i, got, exp);
      end
      if (i == 6) BTN1 = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_press();
    test_glitch();
    test_press();
    test_bounce();
    test_autorepeat();
    test_reset_mid();
    test_min_debounce();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
